mips_instruction_register: RTL

MIPS_INSTRUCTION_REGISTER -- requirements
Module: mips_instruction_register

---
 rtl/mips_pkg.sv | 34 +++
 rtl/mips_byte_swap.sv | 12 +
 rtl/mips_instruction_register.sv | 104 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: IR FSM states and instruction
// field geometry.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    FAULT = 2'd3
  } ir_state_e;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned OFFSET_W  = 16;
  localparam int unsigned TARGET_W  = 26;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned TARGET_LSB = 0;

  // Where a fetch request lands: only word-aligned addresses reach the bus.
  function automatic ir_state_e fetch_target(input logic [1:0] pc_lo);
    return (pc_lo == 2'b00) ? REQ : FAULT;
  endfunction

endpackage

// File: rtl/mips_byte_swap.sv
// Little-endian bus word to big-endian instruction order; pass-through when
// EN is cleared.
module mips_byte_swap #(
  parameter bit EN = 1'b1
) (
  input  logic [31:0] d_i,
  output logic [31:0] d_o
);

  assign d_o = EN ? {d_i[7:0], d_i[15:8], d_i[23:16], d_i[31:24]} : d_i;

endmodule

// File: rtl/mips_instruction_register.sv
// Instruction register with a single-word bus fetcher; holds one instruction
// until consumed and goes sticky-faulted on a misaligned fetch.
module mips_instruction_register
  import mips_pkg::*;
#(
  parameter bit          BYTE_SWAP   = 1'b1,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        ir_consume,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        ir_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] offset,
  output logic [25:0] target,
  output logic        busy,
  output logic        fault
);

  ir_state_e   state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] rdata_be;

  mips_byte_swap #(.EN(BYTE_SWAP)) u_swap (
    .d_i (mem_readdata),
    .d_o (rdata_be)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= RESET_INSTR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
    end
  end

  // Outputs decode from state_q only; mem_waitrequest steers next state alone.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    mem_read = 1'b0;
    busy     = 1'b0;
    ir_valid = 1'b0;
    fault    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_req) begin
          state_d = fetch_target(pc[1:0]);
          addr_d  = pc;
        end
      end
      REQ: begin
        mem_read = 1'b1;
        busy     = 1'b1;
        if (!mem_waitrequest) begin
          instr_d = rdata_be;
          state_d = FULL;
        end
      end
      FULL: begin
        ir_valid = 1'b1;
        if (ir_consume) begin
          state_d = IDLE;
          if (fetch_req) begin
            state_d = fetch_target(pc[1:0]);
            addr_d  = pc;
          end
        end
      end
      FAULT: fault = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign mem_address = addr_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_LSB +: OPCODE_W];
  assign rs          = instr_q[RS_LSB     +: REG_W];
  assign rt          = instr_q[RT_LSB     +: REG_W];
  assign rd          = instr_q[RD_LSB     +: REG_W];
  assign shamt       = instr_q[SHAMT_LSB  +: SHAMT_W];
  assign funct       = instr_q[FUNCT_LSB  +: FUNCT_W];
  assign offset      = instr_q[OFFSET_LSB +: OFFSET_W];
  assign target      = instr_q[TARGET_LSB +: TARGET_W];

endmodule
